// File: rtl/ysyx_040066_trap_ctrl.sv
// Machine-mode trap controller: M-mode CSR file, timer interrupt arming,
// and ecall/mret/interrupt redirect generation at instruction-retire boundaries.
module ysyx_040066_trap_ctrl #(
  parameter logic [63:0] MTVEC_RST = 64'h0000_0000_8000_0000,
  parameter bit          VEC_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        intr,
  input  logic        commit_valid,
  input  logic [63:0] commit_pc,
  input  logic [63:0] commit_npc,
  input  logic        commit_ecall,
  input  logic        commit_mret,
  input  logic        csr_wen,
  input  logic [11:0] csr_addr,
  input  logic [63:0] csr_wdata,
  output logic [63:0] csr_rdata,
  output logic        csr_illegal,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, ARMED, TRAP} state_t;

  localparam int NCSR = 7;
  // Slot order: mstatus, mie, mtvec, mscratch, mepc, mcause, mip
  localparam logic [NCSR*12-1:0] CSR_MAP = {12'h344, 12'h342, 12'h341, 12'h340,
                                            12'h305, 12'h304, 12'h300};

  state_t      state_reg;
  logic        mstatus_mie_reg;
  logic        mstatus_mpie_reg;
  logic        mie_mtie_reg;
  logic        mtip_reg;
  logic [63:0] mtvec_reg;
  logic [63:0] mscratch_reg;
  logic [63:0] mepc_reg;
  logic [63:0] mcause_reg;
  logic        redirect_valid_reg;
  logic [63:0] redirect_pc_reg;

  logic [NCSR-1:0] csr_hit;
  logic [NCSR-1:0] csr_wsel;
  logic [63:0]     csr_val [NCSR];
  logic [63:0]     mepc_rd;
  logic [63:0]     tvec_base;
  logic [63:0]     tvec_int;
  logic            pend;
  logic            csr_wr;
  logic            unused_mepc_low;

  assign mepc_rd         = {mepc_reg[63:2], 2'b00};
  assign unused_mepc_low = ^mepc_reg[1:0];
  assign tvec_base       = {mtvec_reg[63:2], 2'b00};
  assign tvec_int        = (VEC_EN && mtvec_reg[1:0] == 2'b01) ? tvec_base + 64'd28 : tvec_base;
  assign pend            = mtip_reg & mie_mtie_reg & mstatus_mie_reg;
  // The pipeline is squashing during TRAP, so any commit then is ignored entirely.
  assign csr_wr          = commit_valid & csr_wen & (state_reg != TRAP);

  assign csr_val[0] = {51'b0, 2'b11, 3'b0, mstatus_mpie_reg, 3'b0, mstatus_mie_reg, 3'b0};
  assign csr_val[1] = {56'b0, mie_mtie_reg, 7'b0};
  assign csr_val[2] = mtvec_reg;
  assign csr_val[3] = mscratch_reg;
  assign csr_val[4] = mepc_rd;
  assign csr_val[5] = mcause_reg;
  assign csr_val[6] = {56'b0, mtip_reg, 7'b0};

  genvar gi;
  generate
    for (gi = 0; gi < NCSR; gi++) begin : g_dec
      assign csr_hit[gi]  = (csr_addr == CSR_MAP[gi*12 +: 12]);
      assign csr_wsel[gi] = csr_hit[gi] & csr_wr;
    end
  endgenerate

  always_comb begin
    csr_rdata = '0;
    for (int i = 0; i < NCSR; i++) begin
      if (csr_hit[i]) csr_rdata = csr_rdata | csr_val[i];
    end
  end

  assign csr_illegal    = ~|csr_hit;
  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      mstatus_mie_reg    <= 1'b0;
      mstatus_mpie_reg   <= 1'b0;
      mie_mtie_reg       <= 1'b0;
      mtip_reg           <= 1'b0;
      mtvec_reg          <= MTVEC_RST;
      mscratch_reg       <= '0;
      mepc_reg           <= '0;
      mcause_reg         <= '0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
    end else begin
      mtip_reg           <= intr;
      redirect_valid_reg <= 1'b0;

      // Plain CSR writes first; trap side effects below override mstatus/mepc/mcause.
      if (csr_wsel[0]) begin
        mstatus_mie_reg  <= csr_wdata[3];
        mstatus_mpie_reg <= csr_wdata[7];
      end
      if (csr_wsel[1]) mie_mtie_reg <= csr_wdata[7];
      if (csr_wsel[2]) mtvec_reg    <= csr_wdata;
      if (csr_wsel[3]) mscratch_reg <= csr_wdata;
      if (csr_wsel[4]) mepc_reg     <= csr_wdata;
      if (csr_wsel[5]) mcause_reg   <= csr_wdata;

      case (state_reg)
        IDLE, ARMED: begin
          if (commit_valid && commit_ecall) begin
            mepc_reg           <= commit_pc;
            mcause_reg         <= 64'd11;
            mstatus_mpie_reg   <= mstatus_mie_reg;
            mstatus_mie_reg    <= 1'b0;
            redirect_pc_reg    <= tvec_base;
            redirect_valid_reg <= 1'b1;
            state_reg          <= TRAP;
          end else if (commit_valid && commit_mret) begin
            mstatus_mie_reg    <= mstatus_mpie_reg;
            mstatus_mpie_reg   <= 1'b1;
            redirect_pc_reg    <= mepc_rd;
            redirect_valid_reg <= 1'b1;
            state_reg          <= TRAP;
          end else if (state_reg == ARMED && commit_valid) begin
            mepc_reg           <= commit_npc;
            mcause_reg         <= 64'h8000_0000_0000_0007;
            mstatus_mpie_reg   <= mstatus_mie_reg;
            mstatus_mie_reg    <= 1'b0;
            redirect_pc_reg    <= tvec_int;
            redirect_valid_reg <= 1'b1;
            state_reg          <= TRAP;
          end else if (pend) begin
            state_reg <= ARMED;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_040066_trap_ctrl.sv
// Scoreboard bench for the trap controller: directed scenarios push expected
// redirects (pc + cycle); a negedge monitor pops and compares each pulse.
`timescale 1ns/100ps
module tb_ysyx_040066_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        intr = 1'b0;
  logic        commit_valid = 1'b0;
  logic [63:0] commit_pc = '0;
  logic [63:0] commit_npc = '0;
  logic        commit_ecall = 1'b0;
  logic        commit_mret = 1'b0;
  logic        csr_wen = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [63:0] csr_wdata = '0;
  logic [63:0] csr_rdata;
  logic        csr_illegal;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  ysyx_040066_trap_ctrl dut (
    .clk(clk), .rst(rst), .intr(intr),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_npc(commit_npc),
    .commit_ecall(commit_ecall), .commit_mret(commit_mret),
    .csr_wen(csr_wen), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%016h", name, act);
    end
  endtask

  // Monitor: every redirect pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (redirect_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_redirect: got pc 0x%016h at cycle %0d expected none",
                 redirect_pc, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("redirect_pc", redirect_pc, e.pc);
        check("redirect_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] pc, input int unsigned at);
    exp_t e;
    e.pc  = pc;
    e.cyc = at;
    sb_q.push_back(e);
  endtask

  task automatic rd(input string name, input logic [11:0] addr, input logic [63:0] exp);
    csr_addr = addr;
    #0.5;
    check(name, csr_rdata, exp);
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [63:0] data);
    commit_valid = 1'b1;
    csr_wen      = 1'b1;
    csr_addr     = addr;
    csr_wdata    = data;
    step();
    commit_valid = 1'b0;
    csr_wen      = 1'b0;
  endtask

  task automatic check_reset_csrs(input string tag);
    rd({tag, "_mstatus"}, 12'h300, 64'h1800);
    rd({tag, "_mie"}, 12'h304, 64'h0);
    rd({tag, "_mtvec"}, 12'h305, 64'h8000_0000);
    rd({tag, "_mscratch"}, 12'h340, 64'h0);
    rd({tag, "_mepc"}, 12'h341, 64'h0);
    rd({tag, "_mcause"}, 12'h342, 64'h0);
    rd({tag, "_mip"}, 12'h344, 64'h0);
    check({tag, "_redirect_pc"}, redirect_pc, 64'h0);
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state and decode
    check("reset_redirect_valid", 64'(redirect_valid), 64'h0);
    check_reset_csrs("rst");
    csr_addr = 12'h123;
    #0.5;
    check("illegal_addr_flag", 64'(csr_illegal), 64'h1);
    check("illegal_addr_rdata", csr_rdata, 64'h0);
    csr_addr = 12'h305;
    #0.5;
    check("legal_addr_flag", 64'(csr_illegal), 64'h0);

    // 1: direct-mode timer interrupt, redirect 3 cycles after intr
    step();
    csr_write(12'h305, 64'h8000_0100);
    csr_write(12'h304, 64'h80);
    csr_write(12'h300, 64'h1808);
    intr = 1'b1;
    commit_valid = 1'b1;
    commit_npc = 64'h8000_0040;
    push(64'h8000_0100, cyc + 3);
    repeat (3) step();
    commit_valid = 1'b0;
    step();
    rd("t1_mepc", 12'h341, 64'h8000_0040);
    rd("t1_mcause", 12'h342, 64'h8000_0000_0000_0007);
    rd("t1_mstatus", 12'h300, 64'h1880);

    // 5: mret back to mepc, then retrap at next boundary since intr is still high
    commit_valid = 1'b1;
    commit_mret = 1'b1;
    push(64'h8000_0040, cyc + 1);
    push(64'h8000_0100, cyc + 4);
    step();
    commit_valid = 1'b0;
    commit_mret = 1'b0;
    rd("t5_mstatus_after_mret", 12'h300, 64'h1888);
    step();
    commit_valid = 1'b1;
    commit_npc = 64'h8000_0044;
    step();
    step();
    commit_valid = 1'b0;
    step();
    rd("t5_mepc_retrap", 12'h341, 64'h8000_0044);
    rd("t5_mstatus_retrap", 12'h300, 64'h1880);
    intr = 1'b0;
    step();

    // 2: vectored mode interrupt, then ecall goes to base
    csr_write(12'h305, 64'h8000_0101);
    csr_write(12'h300, 64'h1808);
    intr = 1'b1;
    commit_valid = 1'b1;
    commit_npc = 64'h8000_0080;
    push(64'h8000_011C, cyc + 3);
    repeat (3) step();
    commit_valid = 1'b0;
    intr = 1'b0;
    step();
    rd("t2_mepc_int", 12'h341, 64'h8000_0080);
    rd("t2_mcause_int", 12'h342, 64'h8000_0000_0000_0007);
    commit_valid = 1'b1;
    commit_ecall = 1'b1;
    commit_pc = 64'h8000_0200;
    commit_npc = 64'h8000_0204;
    push(64'h8000_0100, cyc + 1);
    step();
    commit_valid = 1'b0;
    commit_ecall = 1'b0;
    rd("t2_mcause_ecall", 12'h342, 64'd11);
    rd("t2_mepc_ecall", 12'h341, 64'h8000_0200);
    rd("t2_mstatus_ecall", 12'h300, 64'h1800);
    step();

    // 3: MIE=0 masks a long intr; mip is read-only; enabling MIE traps promptly
    intr = 1'b1;
    repeat (100) step();
    rd("t3_mip", 12'h344, 64'h80);
    csr_write(12'h344, 64'h0);
    rd("t3_mip_write_ignored", 12'h344, 64'h80);
    csr_write(12'h300, 64'h1808);
    commit_valid = 1'b1;
    commit_npc = 64'h8000_0300;
    push(64'h8000_011C, cyc + 2);
    step();
    step();
    commit_valid = 1'b0;
    intr = 1'b0;
    step();
    rd("t3_mepc", 12'h341, 64'h8000_0300);

    // 4: ARMED without a commit, intr drops -> back to IDLE, no trap
    csr_write(12'h300, 64'h1808);
    intr = 1'b1;
    step();
    step();
    intr = 1'b0;
    step();
    step();
    commit_valid = 1'b1;
    commit_npc = 64'h8000_0500;
    step();
    step();
    commit_valid = 1'b0;
    step();
    rd("t4_mepc_unchanged", 12'h341, 64'h8000_0300);
    rd("t4_mstatus_unchanged", 12'h300, 64'h1808);

    // Plain CSR storage, including mepc low-bit masking
    csr_write(12'h340, 64'hDEAD_BEEF_CAFE_F00D);
    rd("mscratch_rw", 12'h340, 64'hDEAD_BEEF_CAFE_F00D);
    csr_write(12'h341, 64'h8000_0043);
    rd("mepc_low_bits", 12'h341, 64'h8000_0040);

    // 6: reset during the TRAP cycle suppresses further pulses and clears state
    commit_valid = 1'b1;
    commit_ecall = 1'b1;
    commit_pc = 64'h8000_0600;
    push(64'h8000_0100, cyc + 1);
    step();
    commit_valid = 1'b0;
    commit_ecall = 1'b0;
    rst = 1'b1;
    step();
    check("t6_redirect_valid", 64'(redirect_valid), 64'h0);
    check_reset_csrs("t6");
    rst = 1'b0;
    repeat (5) step();

    check("scoreboard_drained", 64'(sb_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
